// File: rtl/ddr_req_scheduler_if.sv
// Requester-side and memory-controller-side signals of ddr_req_scheduler.
// slave is the scheduler's view; master is the view of whatever drives it.
interface ddr_req_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_done;
    logic              req0_err;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_done;
    logic              req1_err;
    logic [DATA_W-1:0] req1_rdata;

    logic              mc_write_en;
    logic              mc_read_en;
    logic [ADDR_W-1:0] mc_address;
    logic [DATA_W-1:0] mc_data_in;
    logic              mc_clk_enable;
    logic              mc_refresh;
    logic              mc_ready;
    logic [DATA_W-1:0] mc_rdata;
    logic              busy;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_err, req1_rdata,
        output mc_write_en, mc_read_en, mc_address, mc_data_in,
        output mc_clk_enable, mc_refresh, busy,
        input  mc_ready, mc_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_err, req1_rdata,
        input  mc_write_en, mc_read_en, mc_address, mc_data_in,
        input  mc_clk_enable, mc_refresh, busy,
        output mc_ready, mc_rdata
    );
endinterface

// File: rtl/ddr_req_scheduler.sv
// Two-port round-robin front end for a DDR controller command path,
// with periodic refresh windows and a ready timeout.
module ddr_req_scheduler #(
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = 16,
    parameter int REFRESH_INTERVAL = 7800,
    parameter int REFRESH_CYCLES   = 8,
    parameter int TIMEOUT          = 64
) (
    input logic                clk,
    input logic                reset,
    ddr_req_scheduler_if.slave bus
);
    localparam int RW = $clog2(REFRESH_INTERVAL + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);

    localparam logic [RW-1:0] REF_LOAD  = RW'(REFRESH_INTERVAL - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WIN_LAST  = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        REFRESH
    } state_t;

    state_t            state;
    logic              rr_ptr;
    logic              refresh_due;
    logic              port;
    logic [RW-1:0]     ref_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [CW-1:0]     win_cnt;

    logic              grant_vld;
    logic              grant;
    logic              accept;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        grant     = (bus.req0_valid & bus.req1_valid) ? rr_ptr
                                                      : bus.req1_valid;
        accept    = !reset && (state == IDLE) && !refresh_due && grant_vld;
        sel_write = grant ? bus.req1_write : bus.req0_write;
        sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
    end

    assign bus.req0_ready = accept & !grant;
    assign bus.req1_ready = accept & grant;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= 1'b0;
            refresh_due       <= 1'b0;
            port              <= 1'b0;
            ref_cnt           <= REF_LOAD;
            wait_cnt          <= '0;
            win_cnt           <= '0;
            bus.req0_done     <= 1'b0;
            bus.req0_err      <= 1'b0;
            bus.req0_rdata    <= '0;
            bus.req1_done     <= 1'b0;
            bus.req1_err      <= 1'b0;
            bus.req1_rdata    <= '0;
            bus.mc_write_en   <= 1'b0;
            bus.mc_read_en    <= 1'b0;
            bus.mc_address    <= '0;
            bus.mc_data_in    <= '0;
            bus.mc_clk_enable <= 1'b0;
            bus.mc_refresh    <= 1'b0;
        end else begin
            bus.mc_clk_enable <= 1'b1;
            bus.req0_done     <= 1'b0;
            bus.req1_done     <= 1'b0;
            bus.req0_err      <= 1'b0;
            bus.req1_err      <= 1'b0;
            ref_cnt <= (ref_cnt == '0) ? REF_LOAD : ref_cnt - 1'b1;

            unique case (state)
                IDLE: begin
                    if (refresh_due) begin
                        refresh_due    <= 1'b0;
                        bus.mc_refresh <= 1'b1;
                        win_cnt        <= '0;
                        state          <= REFRESH;
                    end else if (grant_vld) begin
                        port            <= grant;
                        rr_ptr          <= !grant;
                        bus.mc_write_en <= sel_write;
                        bus.mc_read_en  <= !sel_write;
                        bus.mc_address  <= sel_addr;
                        bus.mc_data_in  <= sel_wdata;
                        wait_cnt        <= '0;
                        state           <= BUSY;
                    end
                end
                REFRESH: begin
                    if (win_cnt == WIN_LAST) begin
                        bus.mc_refresh <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    // ready on the last allowed cycle still counts as success
                    if (bus.mc_ready || wait_cnt == WAIT_LAST) begin
                        bus.mc_write_en <= 1'b0;
                        bus.mc_read_en  <= 1'b0;
                        state           <= DONE;
                        if (port) begin
                            bus.req1_done <= 1'b1;
                            bus.req1_err  <= !bus.mc_ready;
                            if (bus.mc_ready && bus.mc_read_en)
                                bus.req1_rdata <= bus.mc_rdata;
                        end else begin
                            bus.req0_done <= 1'b1;
                            bus.req0_err  <= !bus.mc_ready;
                            if (bus.mc_ready && bus.mc_read_en)
                                bus.req0_rdata <= bus.mc_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // a tick coinciding with the refresh hand-off must not be lost
            if (ref_cnt == '0)
                refresh_due <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr_req_scheduler.sv
// Bench for ddr_req_scheduler: cycle model plus directed latency checks.
module tb_ddr_req_scheduler;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int RI = 20;
    localparam int RC = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ddr_req_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ddr_req_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(RI),
        .REFRESH_CYCLES(RC), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_started = 0;
    int          m_cyc;
    bit          m_due, m_job, m_jport, m_jwrite, m_done, m_dport, m_derr;
    bit          m_rr, m_clken;
    int          m_jwait, m_ref_left;
    logic [31:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] m_rdata [2];

    function automatic int m_gp();
        if (bus.req0_valid && bus.req1_valid) return m_rr ? 1 : 0;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit m_idle();
        return !m_job && !m_done && m_ref_left == 0;
    endfunction

    always @(posedge clk) begin
        int gp;
        if (reset) begin
            m_started = 1; m_cyc = 0; m_due = 0; m_job = 0; m_done = 0;
            m_dport = 0; m_derr = 0; m_rr = 0; m_clken = 0; m_jwait = 0;
            m_ref_left = 0; m_addr = 0; m_data = 0; m_jport = 0; m_jwrite = 0;
            m_rdata[0] = 0; m_rdata[1] = 0;
        end else begin
            gp = m_gp();
            m_clken = 1;
            m_cyc++;
            if (m_done) m_done = 0;
            else if (m_ref_left > 0) m_ref_left--;
            else if (m_job) begin
                if (bus.mc_ready) begin
                    if (!m_jwrite) m_rdata[m_jport] = bus.mc_rdata;
                    m_done = 1; m_dport = m_jport; m_derr = 0; m_job = 0;
                end else if (m_jwait == TO - 1) begin
                    m_done = 1; m_dport = m_jport; m_derr = 1; m_job = 0;
                end else m_jwait++;
            end else if (m_due) begin
                m_due = 0; m_ref_left = RC;
            end else if (gp >= 0) begin
                m_job = 1; m_jport = gp[0]; m_jwait = 0; m_rr = (gp == 0);
                m_jwrite = gp[0] ? bus.req1_write : bus.req0_write;
                m_addr   = gp[0] ? bus.req1_addr  : bus.req0_addr;
                m_data   = gp[0] ? bus.req1_wdata : bus.req0_wdata;
            end
            if (m_cyc % RI == 0) m_due = 1;
        end
    end

    always @(negedge clk) begin
        int gp;
        bit idle, r0, r1;
        if (m_started) begin
            gp   = m_gp();
            idle = m_idle();
            r0 = !reset && idle && !m_due && gp == 0;
            r1 = !reset && idle && !m_due && gp == 1;
            chk("req0_ready", 32'(bus.req0_ready), 32'(r0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(r1));
            chk("two_ready", 32'(bus.req0_ready & bus.req1_ready), 32'(0));
            chk("req0_done", 32'(bus.req0_done), 32'(m_done && !m_dport));
            chk("req1_done", 32'(bus.req1_done), 32'(m_done && m_dport));
            chk("req0_err", 32'(bus.req0_err), 32'(m_done && !m_dport && m_derr));
            chk("req1_err", 32'(bus.req1_err), 32'(m_done && m_dport && m_derr));
            chk("req0_rdata", 32'(bus.req0_rdata), 32'(m_rdata[0]));
            chk("req1_rdata", 32'(bus.req1_rdata), 32'(m_rdata[1]));
            chk("mc_write_en", 32'(bus.mc_write_en), 32'(m_job && m_jwrite));
            chk("mc_read_en", 32'(bus.mc_read_en), 32'(m_job && !m_jwrite));
            chk("mc_address", bus.mc_address, m_addr);
            chk("mc_data_in", 32'(bus.mc_data_in), 32'(m_data));
            chk("mc_clk_enable", 32'(bus.mc_clk_enable), 32'(m_clken));
            chk("mc_refresh", 32'(bus.mc_refresh), 32'(m_ref_left > 0));
            chk("busy", 32'(bus.busy), 32'(!idle));
        end
    end

    // ---------------- observation ----------------
    int          edges = 0;
    int          acc_cyc, done_cyc, rd_cnt, wr_cnt, ref_cnt, done_port;
    int          first_ref = -1;
    bit          done_err;
    logic [15:0] done_rdata, wdata_seen;
    int          acc_q[$];

    always @(posedge clk) begin
        if (reset) edges = 0;
        else edges++;
    end

    always @(negedge clk) begin
        if (reset) begin
            first_ref = -1;
            ref_cnt = 0;
        end
        if (bus.req0_ready || bus.req1_ready) begin
            acc_q.push_back(bus.req1_ready ? 1 : 0);
            acc_cyc = edges; rd_cnt = 0; wr_cnt = 0;
        end
        if (bus.mc_read_en) rd_cnt++;
        if (bus.mc_write_en) begin
            wr_cnt++;
            wdata_seen = bus.mc_data_in;
        end
        if (bus.mc_refresh) begin
            ref_cnt++;
            if (first_ref < 0) first_ref = edges;
        end
        if (bus.req0_done || bus.req1_done) begin
            done_cyc   = edges;
            done_port  = bus.req1_done ? 1 : 0;
            done_err   = bus.req1_done ? bus.req1_err : bus.req0_err;
            done_rdata = bus.req1_done ? bus.req1_rdata : bus.req0_rdata;
        end
    end

    // ---------------- controller responder ----------------
    int          resp_delay = 0;
    int          en_cnt = 0;
    bit          stray = 0;
    logic [15:0] rdata_val = 16'h0;

    always @(posedge clk) begin
        #1;
        if (bus.mc_write_en || bus.mc_read_en) en_cnt++;
        else en_cnt = 0;
        bus.mc_ready = stray || ((bus.mc_write_en || bus.mc_read_en) &&
                                 resp_delay != 0 && en_cnt == resp_delay);
        bus.mc_rdata = rdata_val;
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int p, input bit v, input bit w,
                           input logic [31:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_write = w;
            bus.req0_addr = a;  bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_write = w;
            bus.req1_addr = a;  bus.req1_wdata = d;
        end
    endtask

    task automatic req_wait(input int p, input bit w,
                            input logic [31:0] a, input logic [15:0] d);
        bit got = 0;
        set_req(p, 1'b1, w, a, d);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((p == 0 && bus.req0_ready) || (p == 1 && bus.req1_ready))
                got = 1;
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, w, a, d);
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait port%0d: got no ready want ready", p);
        end
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.req0_done || bus.req1_done) got = 1;
        end
        @(posedge clk); #1;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL done_wait: got no done want done");
        end
    endtask

    int base_ref, d0, qb;

    initial begin
        set_req(0, 1'b0, 1'b0, 32'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // first refresh window, then a timed-out read straddling a tick
        while (edges < 34) begin
            @(posedge clk); #1;
        end
        chk("first_refresh_edge", 32'(first_ref), 32'd21);
        chk("first_refresh_len", 32'(ref_cnt), 32'd4);
        base_ref = ref_cnt;
        rdata_val = 16'h7777;
        resp_delay = 0;
        req_wait(0, 1'b0, 32'h80, 16'h0);
        wait_done();
        chk("to_accept_edge", 32'(acc_cyc), 32'd34);
        chk("to_rd_cycles", 32'(rd_cnt), 32'd8);
        chk("to_wr_cycles", 32'(wr_cnt), 32'd0);
        chk("to_err", 32'(done_err), 32'd1);
        chk("to_port", 32'(done_port), 32'd0);
        chk("to_latency", 32'(done_cyc - acc_cyc), 32'd9);
        d0 = done_cyc;

        // ready on the final allowed cycle is a success
        resp_delay = 8;
        req_wait(1, 1'b1, 32'h90, 16'hCAFE);
        chk("post_refresh_gap", 32'(acc_cyc - d0), 32'd6);
        chk("deferred_refresh_len", 32'(ref_cnt - base_ref), 32'd4);
        wait_done();
        chk("last_cycle_wr", 32'(wr_cnt), 32'd8);
        chk("last_cycle_err", 32'(done_err), 32'd0);
        chk("last_cycle_port", 32'(done_port), 32'd1);
        chk("last_cycle_latency", 32'(done_cyc - acc_cyc), 32'd9);

        // port0 read, ready on third enable cycle
        resp_delay = 3;
        rdata_val = 16'hBEEF;
        req_wait(0, 1'b0, 32'h0000_0040, 16'h0);
        wait_done();
        chk("rd_cycles", 32'(rd_cnt), 32'd3);
        chk("rd_wr_cycles", 32'(wr_cnt), 32'd0);
        chk("rd_port", 32'(done_port), 32'd0);
        chk("rd_data", 32'(done_rdata), 32'hBEEF);
        chk("rd_err", 32'(done_err), 32'd0);
        chk("rd_latency", 32'(done_cyc - acc_cyc), 32'd4);

        // stray ready while idle must be ignored
        stray = 1;
        repeat (3) @(posedge clk);
        #1 stray = 0;
        @(posedge clk); #1;

        // port1 write with immediate ready
        resp_delay = 1;
        req_wait(1, 1'b1, 32'h10, 16'h1234);
        wait_done();
        chk("wr_cycles", 32'(wr_cnt), 32'd1);
        chk("wr_rd_cycles", 32'(rd_cnt), 32'd0);
        chk("wr_data", 32'(wdata_seen), 32'h1234);
        chk("wr_port", 32'(done_port), 32'd1);
        chk("wr_latency", 32'(done_cyc - acc_cyc), 32'd2);

        // both ports saturated
        rdata_val = 16'h5A5A;
        qb = acc_q.size();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    req_wait(0, 1'b0, 32'h100 + 32'(i), 16'h0);
            end
            begin
                for (int j = 0; j < 4; j++)
                    req_wait(1, 1'b1, 32'h200 + 32'(j), 16'h1000 + 16'(j));
            end
        join
        wait_done();
        for (int k = 0; k < 8; k++)
            chk($sformatf("rr_grant%0d", k), 32'(acc_q[qb + k]), 32'(k % 2));

        // reset while a request is in flight
        resp_delay = 0;
        req_wait(0, 1'b0, 32'h300, 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h400, 16'h0);
        set_req(1, 1'b1, 1'b1, 32'h500, 16'h0055);
        @(negedge clk);
        chk("rst_read_en", 32'(bus.mc_read_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done0", 32'(bus.req0_done), 32'd0);
        chk("rst_clk_enable", 32'(bus.mc_clk_enable), 32'd0);
        chk("rst_rr_ready0", 32'(bus.req0_ready), 32'd1);
        chk("rst_rr_ready1", 32'(bus.req1_ready), 32'd0);
        resp_delay = 1;
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h400, 16'h0);
        wait_done();
        chk("rst_next_port", 32'(done_port), 32'd0);
        chk("rst_next_err", 32'(done_err), 32'd0);
        req_wait(1, 1'b1, 32'h500, 16'h0055);
        wait_done();
        chk("rst_second_port", 32'(done_port), 32'd1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
